dmem_access: RTL and testbench
==============================

Name: dmem_access

Overview:
- Data-memory access unit between the EX stage and the EX/MEM pipeline register.
- Turns a load/store request from EX into a single-beat valid/ready transaction on the data bus: byte enables, store-data lane replication, load sign/zero extension.
- Holds the pipeline stalled until the bus responds, or until a timeout fires.
- Faults misaligned and illegal accesses without touching the bus.

Parameters:
- TIMEOUT, 255: max cycles in BUSY before abort; 0 disables timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- Clock  in  1  clock.
- nReset  in  1  async active-low reset.
- Rmem  in  1  EX load request.
- Wmem  in  1  EX store request; Rmem&Wmem together is a fault.
- funct3  in  3  access size/sign, RV32 encoding.
- addr  in  32  byte address from ALU result.
- wdata  in  32  store data (rs2).
- bus_req  out  1  bus request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  bus accepts/completes the beat.
- bus_rdata  in  32  read data, valid with bus_ready.
- stall  out  1  freeze PC, IF/ID, ID/EX and the EX/MEM register.
- load_data  out  32  extended load result, valid in DONE.
- mem_fault  out  1  misaligned/illegal access (combinational, IDLE only).
- bus_timeout  out  1  one-cycle pulse in DONE when the access aborted.

Behaviour:
- Reset: state IDLE; counter 0; latched addr/be/wdata/we/funct3 = 0; load_data = 0; bus_timeout = 0; bus_req = 0; stall = 0.
- Reset mid-operation: the access is abandoned and bus_req drops asynchronously.
- op = Rmem|Wmem. fault = op & (misaligned | illegal funct3 | Rmem&Wmem).
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extension: select lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- FSM, IDLE:
  - If op & !fault: latch request fields, clear counter, next = BUSY; stall = 1.
  - If fault: mem_fault = 1, stall = 0, no bus activity, stay IDLE.
  - Otherwise: stall = 0.
- FSM, BUSY:
  - bus_req = 1; bus_* driven from latched fields and stable until accepted; stall = 1; counter increments.
  - On bus_ready: load_data <= extended bus_rdata (stores: load_data <= 0), next = DONE.
  - If TIMEOUT != 0 and counter == TIMEOUT-1 without bus_ready: load_data <= 0, bus_timeout <= 1, next = DONE.
  - bus_ready in the same cycle as the timeout wins: normal completion, no timeout.
- FSM, DONE: stall = 0 so the pipeline advances; bus_req = 0; next = IDLE unconditionally. The op still present on inputs is not restarted.
- Latency: minimum 3 cycles per access (IDLE, BUSY with bus_ready, DONE); a zero-wait bus therefore costs 2 stall cycles.
- Back-to-back ops: the second op is seen in IDLE the cycle after DONE.
- bus_ready outside BUSY is ignored.

Decomposition:
- core_types_pkg gets:
  - dmem_state_t enum {IDLE, BUSY, DONE};
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a dmem_req_t struct {addr, be, wdata, we, funct3}.
- One combinational sub-module, load_store_align:
  - inputs funct3, addr[1:0], wdata, rdata;
  - outputs be, wdata_rep, rdata_ext, misaligned, illegal.
- The FSM, timeout counter and registers stay in dmem_access.

Test Plan:
1. SW addr=0x104, wdata=0xDEADBEEF, bus_ready on 1st BUSY cycle -> bus_be=4'hF, bus_addr=0x104, bus_we=1; stall high exactly 2 cycles; DONE follows.
2. LB addr=0x203, bus_rdata=0x80FF_FF7F -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x202 -> 0xFFFF80FF.
3. SH addr=0x102, wdata=0x1234ABCD -> bus_be=4'b1100, bus_wdata=0xABCDABCD. SB addr=0x101 -> bus_be=4'b0010.
4. LW addr=0x102 -> mem_fault=1 in the same cycle, stall=0, bus_req never asserts; funct3=011 with Rmem -> mem_fault=1.
5. TIMEOUT=4, LW with bus_ready held low -> bus_req high 4 cycles, then DONE with bus_timeout=1, load_data=0, stall released.
6. nReset asserted during BUSY -> bus_req and stall drop immediately; after release, state IDLE and a new LW completes normally.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared types for the data-memory access path: FSM states, RV32 load/store
// size encodings and the latched request record.
package core_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  funct3;
  } dmem_req_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// lane selection with sign/zero extension, and alignment/encoding checks.
module load_store_align
  import core_types_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] lane;

  // Shift the addressed lane down to bit 0 so extension works on a fixed slice.
  assign lane = rdata >> {addr, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{lane[7]}}, lane[7:0]}
                                     : {24'h000000, lane[7:0]};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << addr;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = (funct3 == F3_H) ? {{16{lane[15]}}, lane[15:0]}
                                      : {16'h0000, lane[15:0]};
        misaligned = addr[0];
      end
      F3_W: begin
        be         = 4'b1111;
        misaligned = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// Data-memory access unit: turns an EX load/store into one valid/ready bus
// beat, stalling the pipeline until the bus answers or the timeout fires.
module dmem_access
  import core_types_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Rmem,
  input  logic        Wmem,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        mem_fault,
  output logic        bus_timeout
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  dmem_state_t      state, state_next;
  dmem_req_t        req;
  logic [CNT_W-1:0] cnt;

  logic        op, fault, take, timeout_hit;
  logic        illegal, illegal_f3, misaligned;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;

  // The aligner sees live inputs while IDLE and the latched request afterwards,
  // so one instance serves both request decode and response extension.
  assign sel_f3  = (state == IDLE) ? funct3    : req.funct3;
  assign sel_off = (state == IDLE) ? addr[1:0] : req.addr[1:0];

  load_store_align u_align (
    .funct3     (sel_f3),
    .addr       (sel_off),
    .wdata      (wdata),
    .rdata      (bus_rdata),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned),
    .illegal    (illegal_f3)
  );

  // Unsigned sizes only exist for loads.
  assign illegal     = illegal_f3 | (Wmem & funct3[2]);
  assign op          = Rmem | Wmem;
  assign fault       = op & (misaligned | illegal | (Rmem & Wmem));
  assign take        = (state == IDLE) & op & ~fault;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST) && !bus_ready;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = BUSY;
      BUSY:    if (bus_ready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    stall     = 1'b0;
    mem_fault = 1'b0;
    case (state)
      IDLE: begin
        stall     = take;
        mem_fault = fault;
      end
      BUSY: begin
        bus_req = 1'b1;
        stall   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_we    = req.we;
  assign bus_addr  = {req.addr[31:2], 2'b00};
  assign bus_be    = req.be;
  assign bus_wdata = req.wdata;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      req <= '0;
      cnt <= '0;
    end else if (take) begin
      req <= '{addr: addr, be: be, wdata: wdata_rep, we: Wmem, funct3: funct3};
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Stores and aborted accesses report zero so stale data never reaches WB.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      load_data   <= '0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= (state == BUSY) && timeout_hit;
      if (state == BUSY) begin
        if (bus_ready)        load_data <= req.we ? 32'h0 : rdata_ext;
        else if (timeout_hit) load_data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Randomized bench for dmem_access: directed cases plus random accesses,
// each checked against an arithmetic model of the access rules.
module tb_dmem_access;

  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Rmem, Wmem;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        mem_fault, bus_timeout;

  int n_compared   = 0;
  int n_mismatched = 0;

  dmem_access #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Rmem        (Rmem),
    .Wmem        (Wmem),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata),
    .stall       (stall),
    .load_data   (load_data),
    .mem_fault   (mem_fault),
    .bus_timeout (bus_timeout)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One complete access: IDLE decode, BUSY with `wait_n` wait states, DONE.
  task automatic applyStimulus(input logic rm, input logic wm, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int wait_n, input logic [31:0] rd);
    int          bytes, off, busy_n;
    bit          legal, fault, timed_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld;
    longint      mask, tmp;

    bytes = 1 << f3[1:0];
    off   = int'(a[1:0]);
    legal = (f3[1:0] != 2'b11) && (!f3[2] || (rm && !wm && f3[1:0] != 2'b10));
    fault = (rm || wm) && ((rm && wm) || !legal || (off % bytes) != 0);
    exp_be = 4'(((1 << bytes) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % bytes) +: 8];
    mask = (bytes == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8*bytes)) - 1);
    tmp  = longint'(rd >> (8*off)) & mask;
    if (!f3[2] && bytes < 4 && tmp[8*bytes-1]) tmp = tmp | (~mask);
    timed_out = (wait_n >= TO);
    busy_n    = timed_out ? TO : wait_n + 1;
    exp_ld    = (wm || timed_out) ? 32'h0 : tmp[31:0];

    @(negedge Clock);
    Rmem = rm; Wmem = wm; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    #1;
    checkOutput("idle_fault", mem_fault, fault);
    checkOutput("idle_stall", stall, !fault && (rm || wm));
    if (fault || !(rm || wm)) begin
      @(negedge Clock); #1;
      checkOutput("idle_no_req", bus_req, 1'b0);
      Rmem = 1'b0; Wmem = 1'b0;
      return;
    end
    for (int c = 0; c < busy_n; c++) begin
      @(negedge Clock);
      bus_ready = (c == wait_n);
      bus_rdata = (c == wait_n) ? rd : $urandom;
      #1;
      checkOutput("busy_req", bus_req, 1'b1);
      checkOutput("busy_stall", stall, 1'b1);
      checkOutput("busy_addr", bus_addr, {a[31:2], 2'b00});
      checkOutput("busy_be", bus_be, exp_be);
      checkOutput("busy_we", bus_we, wm);
      if (wm) checkOutput("busy_wdata", bus_wdata, exp_wd);
    end
    @(negedge Clock);
    bus_ready = 1'($urandom); Rmem = 1'b0; Wmem = 1'b0;
    #1;
    checkOutput("done_stall", stall, 1'b0);
    checkOutput("done_req", bus_req, 1'b0);
    checkOutput("done_load", load_data, exp_ld);
    checkOutput("done_timeout", bus_timeout, timed_out);
    @(negedge Clock); #1;
    checkOutput("after_timeout", bus_timeout, 1'b0);
    checkOutput("after_req", bus_req, 1'b0);
    bus_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nReset = 1'b0; Rmem = 1'b0; Wmem = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    #12;
    checkOutput("rst_req", bus_req, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_load", load_data, 32'h0);
    checkOutput("rst_timeout", bus_timeout, 1'b0);
    checkOutput("rst_be", bus_be, 4'h0);
    checkOutput("rst_addr", bus_addr, 32'h0);
    @(negedge Clock); nReset = 1'b1;

    // Directed cases from the access rules.
    applyStimulus(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 32'h0);
    applyStimulus(1, 0, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFF7F);
    applyStimulus(1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h80FFFF7F);
    applyStimulus(1, 0, 3'b001, 32'h202, 32'h0, 2, 32'h80FFFF7F);
    applyStimulus(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0);
    applyStimulus(0, 1, 3'b000, 32'h101, 32'h1234ABCD, 3, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    applyStimulus(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
    applyStimulus(0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h300, 32'h0, 10, 32'h12345678);
    applyStimulus(1, 0, 3'b010, 32'h304, 32'h0, TO - 1, 32'hCAFEF00D);

    // Reset during BUSY abandons the access at once.
    @(negedge Clock);
    Rmem = 1'b1; Wmem = 1'b0; funct3 = 3'b010; addr = 32'h400; bus_ready = 1'b0;
    @(negedge Clock); #1;
    checkOutput("pre_rst_req", bus_req, 1'b1);
    nReset = 1'b0; Rmem = 1'b0;
    #1;
    checkOutput("mid_rst_req", bus_req, 1'b0);
    checkOutput("mid_rst_stall", stall, 1'b0);
    @(negedge Clock); nReset = 1'b1;
    applyStimulus(1, 0, 3'b010, 32'h408, 32'h0, 1, 32'hA5A55A5A);

    for (int n = 0; n < 300; n++) begin
      logic        rm, wm;
      logic [31:0] a;
      rm = 1'($urandom);
      wm = ($urandom_range(0, 7) == 0) ? rm : !rm;
      a  = $urandom;
      applyStimulus(rm, wm, 3'($urandom), a, $urandom,
                    int'($urandom_range(0, TO + 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
